// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundle of everything that passes between the control unit and the
//   datapath/memory. The control unit is the master: it receives the decoded
//   opcode, ALU flags and the memory ready handshake, and drives every mux
//   select, register enable and memory strobe.
// Signals:
//   opcode          decoded opcode from the instruction register
//   status_reg      ALU flags (bit0 Z, bit1 N, bit2 C, bit3 V)
//   mem_ready       memory access completes this cycle
//   *_mux           datapath mux selects
//   *_write         datapath buffer / register enables
//   mem_read/write  memory strobes
//   halted          CPU stopped on HLT
//   illegal_op      one-cycle pulse on an undefined opcode
//   state           current sequencer state, for debug
interface control_unit_if #(
  parameter int OPCODE_SIZE = 5,
  parameter int WORD_SIZE   = 16
);
  logic [OPCODE_SIZE-1:0] opcode;
  logic [WORD_SIZE-1:0]   status_reg;
  logic                   mem_ready;

  logic [1:0] ALU_in2_mux;
  logic [1:0] data_in_mux;
  logic [1:0] PC_mux;
  logic [1:0] memory_addr_mux;
  logic       mem_out_mux;

  logic reg_buff1_write;
  logic reg_buff2_write;
  logic status_reg_write;
  logic ALU_out_write;
  logic reg_write;
  logic PC_write;
  logic IR_write;

  logic mem_read;
  logic mem_write;

  logic       halted;
  logic       illegal_op;
  logic [2:0] state;

  modport master (
    input  opcode, status_reg, mem_ready,
    output ALU_in2_mux, data_in_mux, PC_mux, memory_addr_mux, mem_out_mux,
    output reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write,
    output reg_write, PC_write, IR_write, mem_read, mem_write,
    output halted, illegal_op, state
  );

  modport slave (
    output opcode, status_reg, mem_ready,
    input  ALU_in2_mux, data_in_mux, PC_mux, memory_addr_mux, mem_out_mux,
    input  reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write,
    input  reg_write, PC_write, IR_write, mem_read, mem_write,
    input  halted, illegal_op, state
  );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   Multicycle sequencer for the 16-bit CPU. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM | WB) and the unit drives all datapath
//   selects/enables and memory strobes combinationally from the current state
//   and the opcode captured during DECODE. Memory accesses in FETCH and MEM
//   stall on the mem_ready handshake.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    control_unit_if master modport (opcode, flags, mem_ready in;
//          selects, enables, strobes, halted, illegal_op, state out)
module control_unit #(
  parameter int OPCODE_SIZE = 5,
  parameter int WORD_SIZE   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_ALU_RR  = 5'b00001;
  localparam logic [4:0] OP_ALU_RI3 = 5'b00010;
  localparam logic [4:0] OP_ALU_RI8 = 5'b00011;
  localparam logic [4:0] OP_LDI     = 5'b00100;
  localparam logic [4:0] OP_LD      = 5'b00101;
  localparam logic [4:0] OP_LDA     = 5'b00110;
  localparam logic [4:0] OP_ST      = 5'b00111;
  localparam logic [4:0] OP_STA     = 5'b01000;
  localparam logic [4:0] OP_JMP     = 5'b01001;
  localparam logic [4:0] OP_JR      = 5'b01010;
  localparam logic [4:0] OP_JAL     = 5'b01011;
  localparam logic [4:0] OP_BZ      = 5'b01100;
  localparam logic [4:0] OP_BNZ     = 5'b01101;
  localparam logic [4:0] OP_BN      = 5'b01110;
  localparam logic [4:0] OP_CMP     = 5'b01111;
  localparam logic [4:0] OP_HLT     = 5'b11111;

  state_t                 state_reg;
  state_t                 state_next;
  logic [OPCODE_SIZE-1:0] op_reg;
  logic                   legal;

  // Only Z and N steer branches; the remaining flag bits are not needed here.
  logic unused_flags;
  assign unused_flags = ^bus.status_reg[WORD_SIZE-1:2];

  // Defined opcodes are the contiguous block up to CMP plus HLT.
  assign legal = (bus.opcode <= OP_CMP) || (bus.opcode == OP_HLT);

  assign bus.state = state_reg;

  // State register; the opcode is captured in DECODE so EXEC/MEM see a stable
  // copy even if the instruction register is reloaded later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg <= bus.opcode;
      end
    end
  end

  // Next-state and output decode. Everything is held at 0 while reset is
  // asserted so nothing in the datapath or memory moves during reset.
  always_comb begin
    state_next           = state_reg;
    bus.ALU_in2_mux      = 2'd0;
    bus.data_in_mux      = 2'd0;
    bus.PC_mux           = 2'd0;
    bus.memory_addr_mux  = 2'd0;
    bus.mem_out_mux      = 1'b0;
    bus.reg_buff1_write  = 1'b0;
    bus.reg_buff2_write  = 1'b0;
    bus.status_reg_write = 1'b0;
    bus.ALU_out_write    = 1'b0;
    bus.reg_write        = 1'b0;
    bus.PC_write         = 1'b0;
    bus.IR_write         = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.halted           = 1'b0;
    bus.illegal_op       = 1'b0;

    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          bus.memory_addr_mux = 2'd0;
          bus.mem_read        = 1'b1;
          if (bus.mem_ready) begin
            bus.IR_write = 1'b1;
            bus.PC_write = 1'b1;
            bus.PC_mux   = 2'd0;
            state_next   = S_DECODE;
          end
        end

        S_DECODE: begin
          bus.reg_buff1_write = 1'b1;
          bus.reg_buff2_write = 1'b1;
          if (bus.opcode == OP_HLT) begin
            state_next = S_HALT;
          end else if (!legal || bus.opcode == OP_NOP) begin
            bus.illegal_op = !legal;
            state_next     = S_FETCH;
          end else begin
            state_next = S_EXEC;
          end
        end

        S_EXEC: begin
          state_next = S_FETCH;
          case (op_reg)
            OP_ALU_RR, OP_ALU_RI3, OP_ALU_RI8: begin
              bus.ALU_in2_mux      = (op_reg == OP_ALU_RR)  ? 2'd0 :
                                     (op_reg == OP_ALU_RI3) ? 2'd1 : 2'd2;
              bus.ALU_out_write    = 1'b1;
              bus.status_reg_write = 1'b1;
              state_next           = S_WB;
            end
            OP_CMP: begin
              bus.ALU_in2_mux      = 2'd0;
              bus.status_reg_write = 1'b1;
            end
            OP_LDI: begin
              bus.reg_write   = 1'b1;
              bus.data_in_mux = 2'd2;
            end
            OP_LD, OP_LDA, OP_ST, OP_STA: begin
              state_next = S_MEM;
            end
            OP_JMP: begin
              bus.PC_write = 1'b1;
              bus.PC_mux   = 2'd1;
            end
            OP_JR: begin
              bus.PC_write = 1'b1;
              bus.PC_mux   = 2'd2;
            end
            // PC was already incremented in FETCH, so data_in_mux=3 links the
            // return address while the jump target loads in the same cycle.
            OP_JAL: begin
              bus.reg_write   = 1'b1;
              bus.data_in_mux = 2'd3;
              bus.PC_write    = 1'b1;
              bus.PC_mux      = 2'd1;
            end
            OP_BZ: begin
              bus.PC_write = bus.status_reg[0];
              bus.PC_mux   = 2'd1;
            end
            OP_BNZ: begin
              bus.PC_write = !bus.status_reg[0];
              bus.PC_mux   = 2'd1;
            end
            OP_BN: begin
              bus.PC_write = bus.status_reg[1];
              bus.PC_mux   = 2'd1;
            end
            default: begin
              state_next = S_FETCH;
            end
          endcase
        end

        // Strobes stay up until memory answers; the load result is written
        // only in the ready cycle so a stalled access never writes early.
        S_MEM: begin
          case (op_reg)
            OP_LD, OP_LDA: begin
              bus.memory_addr_mux = (op_reg == OP_LD) ? 2'd1 : 2'd2;
              bus.mem_read        = 1'b1;
              if (bus.mem_ready) begin
                bus.reg_write   = 1'b1;
                bus.data_in_mux = 2'd1;
              end
            end
            OP_ST: begin
              bus.memory_addr_mux = 2'd1;
              bus.mem_out_mux     = 1'b0;
              bus.mem_write       = 1'b1;
            end
            OP_STA: begin
              bus.memory_addr_mux = 2'd2;
              bus.mem_out_mux     = 1'b1;
              bus.mem_write       = 1'b1;
            end
            default: begin
            end
          endcase
          if (bus.mem_ready) begin
            state_next = S_FETCH;
          end
        end

        S_WB: begin
          bus.reg_write   = 1'b1;
          bus.data_in_mux = 2'd0;
          state_next      = S_FETCH;
        end

        S_HALT: begin
          bus.halted = 1'b1;
        end

        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Scoreboard bench for control_unit. The stimulus process walks whole
//   instructions (opcode, flags, memory wait counts) and, for every clock
//   cycle it drives, pushes the control word the instruction should produce
//   in that cycle. A separate monitor pops one entry per cycle on the falling
//   edge and compares it with the DUT outputs.
module tb_control_unit;

  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_ALU_RR  = 5'd1;
  localparam logic [4:0] OP_ALU_RI3 = 5'd2;
  localparam logic [4:0] OP_ALU_RI8 = 5'd3;
  localparam logic [4:0] OP_LDI     = 5'd4;
  localparam logic [4:0] OP_LD      = 5'd5;
  localparam logic [4:0] OP_LDA     = 5'd6;
  localparam logic [4:0] OP_ST      = 5'd7;
  localparam logic [4:0] OP_STA     = 5'd8;
  localparam logic [4:0] OP_JMP     = 5'd9;
  localparam logic [4:0] OP_JR      = 5'd10;
  localparam logic [4:0] OP_JAL     = 5'd11;
  localparam logic [4:0] OP_BZ      = 5'd12;
  localparam logic [4:0] OP_BNZ     = 5'd13;
  localparam logic [4:0] OP_BN      = 5'd14;
  localparam logic [4:0] OP_CMP     = 5'd15;
  localparam logic [4:0] OP_HLT     = 5'd31;

  // One cycle's worth of observable control outputs.
  typedef struct packed {
    logic [2:0] state;
    logic [1:0] alu_in2;
    logic [1:0] data_in;
    logic [1:0] pc_sel;
    logic [1:0] addr_sel;
    logic       mem_out;
    logic       rb1_w;
    logic       rb2_w;
    logic       sr_w;
    logic       alu_w;
    logic       reg_w;
    logic       pc_w;
    logic       ir_w;
    logic       rd;
    logic       wr;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic clk = 1'b1;
  logic rst_n;

  control_unit_if #(.OPCODE_SIZE(5), .WORD_SIZE(16)) bus ();

  control_unit #(.OPCODE_SIZE(5), .WORD_SIZE(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_compared   = 0;
  int    n_mismatched = 0;

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t e;
    e       = '0;
    e.state = st;
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t a;
    a.state    = bus.state;
    a.alu_in2  = bus.ALU_in2_mux;
    a.data_in  = bus.data_in_mux;
    a.pc_sel   = bus.PC_mux;
    a.addr_sel = bus.memory_addr_mux;
    a.mem_out  = bus.mem_out_mux;
    a.rb1_w    = bus.reg_buff1_write;
    a.rb2_w    = bus.reg_buff2_write;
    a.sr_w     = bus.status_reg_write;
    a.alu_w    = bus.ALU_out_write;
    a.reg_w    = bus.reg_write;
    a.pc_w     = bus.PC_write;
    a.ir_w     = bus.IR_write;
    a.rd       = bus.mem_read;
    a.wr       = bus.mem_write;
    a.halted   = bus.halted;
    a.illegal  = bus.illegal_op;
    return a;
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return (op <= OP_CMP) || (op == OP_HLT);
  endfunction

  function automatic bit is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDA) || (op == OP_ST) || (op == OP_STA);
  endfunction

  function automatic bit is_alu_op(input logic [4:0] op);
    return (op == OP_ALU_RR) || (op == OP_ALU_RI3) || (op == OP_ALU_RI8);
  endfunction

  // What each opcode asks of the datapath in its execute cycle.
  function automatic ctl_t exec_word(input logic [4:0] op, input logic [15:0] flags);
    ctl_t e;
    e = blank(3'd2);
    case (op)
      OP_ALU_RR:  begin e.alu_in2 = 2'd0; e.alu_w = 1; e.sr_w = 1; end
      OP_ALU_RI3: begin e.alu_in2 = 2'd1; e.alu_w = 1; e.sr_w = 1; end
      OP_ALU_RI8: begin e.alu_in2 = 2'd2; e.alu_w = 1; e.sr_w = 1; end
      OP_CMP:     begin e.sr_w = 1; end
      OP_LDI:     begin e.reg_w = 1; e.data_in = 2'd2; end
      OP_JMP:     begin e.pc_w = 1; e.pc_sel = 2'd1; end
      OP_JR:      begin e.pc_w = 1; e.pc_sel = 2'd2; end
      OP_JAL:     begin e.reg_w = 1; e.data_in = 2'd3; e.pc_w = 1; e.pc_sel = 2'd1; end
      OP_BZ:      begin e.pc_w = flags[0];  e.pc_sel = 2'd1; end
      OP_BNZ:     begin e.pc_w = ~flags[0]; e.pc_sel = 2'd1; end
      OP_BN:      begin e.pc_w = flags[1];  e.pc_sel = 2'd1; end
      default:    begin end
    endcase
    return e;
  endfunction

  // Memory-phase word for one cycle, with or without the ready handshake.
  function automatic ctl_t mem_word(input logic [4:0] op, input bit ready);
    ctl_t e;
    e = blank(3'd3);
    case (op)
      OP_LD:  begin e.addr_sel = 2'd1; e.rd = 1; end
      OP_LDA: begin e.addr_sel = 2'd2; e.rd = 1; end
      OP_ST:  begin e.addr_sel = 2'd1; e.mem_out = 0; e.wr = 1; end
      default: begin e.addr_sel = 2'd2; e.mem_out = 1; e.wr = 1; end
    endcase
    if (ready && e.rd) begin
      e.reg_w   = 1;
      e.data_in = 2'd1;
    end
    return e;
  endfunction

  // Drive one clock cycle and queue the control word it should show.
  task automatic step(input ctl_t e, input string tag, input logic ready);
    bus.mem_ready = ready;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) step(blank(3'd0), "reset", 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  // Run one instruction; abort_exec pulls reset at the start of its EXEC.
  task automatic applyStimulus(input logic [4:0] op, input logic [15:0] flags,
                               input int fwait, input int mwait, input bit abort_exec);
    ctl_t e;
    bus.opcode     = op;
    bus.status_reg = flags;
    repeat (fwait) begin
      e    = blank(3'd0);
      e.rd = 1;
      step(e, "fetch_wait", 1'b0);
    end
    e      = blank(3'd0);
    e.rd   = 1;
    e.ir_w = 1;
    e.pc_w = 1;
    step(e, "fetch", 1'b1);

    e         = blank(3'd1);
    e.rb1_w   = 1;
    e.rb2_w   = 1;
    e.illegal = !is_legal(op);
    step(e, "decode", 1'($urandom_range(0, 1)));

    if (op == OP_HLT) begin
      for (int i = 0; i < 10; i++) begin
        e          = blank(3'd5);
        e.halted   = 1;
        bus.opcode = 5'($urandom);
        step(e, "halt", 1'($urandom_range(0, 1)));
      end
      bus.opcode = op;
      return;
    end
    if (!is_legal(op) || op == OP_NOP) return;

    if (abort_exec) begin
      doReset();
      return;
    end

    step(exec_word(op, flags), "exec", 1'($urandom_range(0, 1)));

    if (is_alu_op(op)) begin
      e         = blank(3'd4);
      e.reg_w   = 1;
      e.data_in = 2'd0;
      step(e, "wb", 1'($urandom_range(0, 1)));
    end else if (is_mem_op(op)) begin
      repeat (mwait) step(mem_word(op, 1'b0), "mem_wait", 1'b0);
      step(mem_word(op, 1'b1), "mem", 1'b1);
    end
  endtask

  // Monitor: one queued expectation is due per cycle, checked mid-cycle.
  task automatic checkOutput();
    ctl_t  exp_w;
    ctl_t  act_w;
    string tag;
    exp_w = exp_q.pop_front();
    tag   = tag_q.pop_front();
    act_w = sample();
    n_compared++;
    if (act_w !== exp_w) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: got %h required %h", tag, $time, act_w, exp_w);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput();
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, queue=%0d", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] op;
    bus.opcode     = OP_NOP;
    bus.status_reg = '0;
    bus.mem_ready  = 1'b1;
    rst_n          = 1'b1;
    #1;
    doReset();

    applyStimulus(OP_ALU_RR,  16'h0000, 0, 0, 0);
    applyStimulus(OP_ALU_RI3, 16'h0000, 3, 0, 0);
    applyStimulus(OP_BZ,      16'h0001, 0, 0, 0);
    applyStimulus(OP_BZ,      16'h0000, 0, 0, 0);
    applyStimulus(OP_BNZ,     16'h0001, 0, 0, 0);
    applyStimulus(OP_BNZ,     16'h0000, 0, 0, 0);
    applyStimulus(OP_BN,      16'h0002, 0, 0, 0);
    applyStimulus(OP_LD,      16'h0000, 0, 2, 0);
    applyStimulus(OP_STA,     16'h0000, 1, 1, 0);
    applyStimulus(OP_JAL,     16'h0000, 0, 0, 0);
    applyStimulus(5'b10101,   16'h0000, 0, 0, 0);
    applyStimulus(OP_ALU_RI8, 16'h0000, 0, 0, 1);
    applyStimulus(OP_CMP,     16'h0000, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 30));
      applyStimulus(op, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end

    applyStimulus(OP_HLT, 16'h0000, 0, 0, 0);
    doReset();
    applyStimulus(OP_LDA, 16'h0000, 0, 1, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
